uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_rx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and default bit timing.
package uart_pkg;

  // 100 MHz clock / 115200 baud
  localparam int unsigned ClksPerBitDefault = 868;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit with a configurable reset value.
module sync_2ff #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, valid/ready output, frame error pulse and sticky overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLoad  = CntW'(CLKS_PER_BIT - 1);

  uart_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q;
  logic            rxd_s;
  logic            expire;
  logic            commit;
  logic            frame_fail;

  sync_2ff #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk_i(clk),
    .rst_i(reset),
    .d_i  (rxd),
    .q_o  (rxd_s)
  );

  assign expire = (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (!rxd_s) state_d = StStart;
      StStart:    if (expire) state_d = rxd_s ? StIdle : StData;
      StData:     if (expire && (idx_q == 3'd7)) state_d = StStop;
      StStop:     if (expire) state_d = rxd_s ? StIdle : StWaitIdle;
      StWaitIdle: if (rxd_s) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    commit     = 1'b0;
    frame_fail = 1'b0;
    case (state_q)
      StIdle: begin
        if (!rxd_s) begin
          cnt_d = HalfLoad;
          idx_d = '0;
        end
      end
      StStart: begin
        if (expire) begin
          cnt_d = BitLoad;
          idx_d = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StData: begin
        if (expire) begin
          shift_d[idx_q] = rxd_s;
          cnt_d          = BitLoad;
          idx_d          = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StStop: begin
        if (expire) begin
          commit     = rxd_s;
          frame_fail = !rxd_s;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A transfer and a commit in the same cycle hand over the old byte and load the new one.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
    if (commit) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_fail;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule
